load_store_unit: RTL and testbench

Memory-access stage between the execute stage and `data_memory`. It accepts one load or store request at a time and translates byte, halfword and word accesses into word-wide `data_memory` transactions. Sub-word stores use read-modify-write. It sign- or zero-extends load data and flags misaligned or out-of-range accesses. The execute stage stalls while `READY` is low.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 37 +++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, state encoding and word geometry for the load/store unit
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAITRD,
    ST_WR,
    ST_DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = rd_word[{lane, 3'b000} +: 8];
    lane_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data   = rd_word;
    merged    = st_data;
    case (size)
      SZ_BYTE: begin
        ld_data = {{24{sign & lane_byte[7]}}, lane_byte};
        merged  = rd_word;
        merged[{lane, 3'b000} +: 8] = st_data[7:0];
      end
      SZ_HALF: begin
        ld_data = {{16{sign & lane_half[15]}}, lane_half};
        merged  = rd_word;
        merged[{lane[1], 4'b0000} +: 16] = st_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-at-a-time load/store stage in front of a word-wide data_memory
// Byte/half accesses (read-modify-write stores) exist only when LSU_SUBWORD_EN is defined.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic [31:0] ADDR,
  input  logic [31:0] WDATA,
  output logic        READY,
  output logic        DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        W_DM,
  output logic [31:0] AD,
  output logic [31:0] WP,
  input  logic [31:0] PR
);

  lsu_state_t  state_q, state_d;
  logic        accept;
  logic        acc_err;
  logic        err_q;
  logic [31:0] ad_q;
  logic [31:0] wp_q;
  logic [31:0] rdata_q;

  assign accept = REQ && (state_q == ST_IDLE);

`ifdef LSU_SUBWORD_EN
  logic        we_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [31:0] ld_data;
  logic [31:0] merged;

  // wp_q holds the right-justified store data until WAITRD replaces it with the merged word
  lsu_align u_align (
    .rd_word (PR),
    .st_data (wp_q),
    .lane    (lane_q),
    .size    (size_q),
    .sign    (signed_q),
    .ld_data (ld_data),
    .merged  (merged)
  );
`else
  logic unused_signed;
  assign unused_signed = SIGNED;
`endif

  always_comb begin
    acc_err = 1'b0;
    if (ADDR >= 32'(MEM_WORDS * WORD_BYTES)) acc_err = 1'b1;
`ifdef LSU_SUBWORD_EN
    case (SIZE)
      SZ_BYTE: ;
      SZ_HALF: if (ADDR[0]) acc_err = 1'b1;
      SZ_WORD: if (ADDR[1:0] != 2'b00) acc_err = 1'b1;
      default: acc_err = 1'b1;
    endcase
`else
    if (SIZE != SZ_WORD || ADDR[1:0] != 2'b00) acc_err = 1'b1;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (acc_err)                    state_d = ST_DONE;
          else if (WE && SIZE == SZ_WORD) state_d = ST_WR;
          else                            state_d = ST_RD;
        end
      end
      ST_RD:     state_d = ST_WAITRD;
`ifdef LSU_SUBWORD_EN
      ST_WAITRD: state_d = we_q ? ST_WR : ST_DONE;
`else
      ST_WAITRD: state_d = ST_DONE;
`endif
      ST_WR:     state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_q   <= 1'b0;
      ad_q    <= '0;
      wp_q    <= '0;
      rdata_q <= '0;
`ifdef LSU_SUBWORD_EN
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_WORD;
      lane_q   <= 2'b00;
`endif
    end else begin
      if (accept) begin
        err_q <= acc_err;
        ad_q  <= {2'b00, ADDR[31:2]};
        if (WE) wp_q <= WDATA;
`ifdef LSU_SUBWORD_EN
        we_q     <= WE;
        signed_q <= SIGNED;
        size_q   <= SIZE;
        lane_q   <= ADDR[1:0];
`endif
      end
      if (state_q == ST_WAITRD) begin
`ifdef LSU_SUBWORD_EN
        if (we_q) wp_q    <= merged;
        else      rdata_q <= ld_data;
`else
        rdata_q <= PR;
`endif
      end
    end
  end

  assign READY = (state_q == ST_IDLE);
  assign DONE  = (state_q == ST_DONE);
  assign ERR   = (state_q == ST_DONE) && err_q;
  assign W_DM  = (state_q == ST_WR);
  assign AD    = ad_q;
  assign WP    = wp_q;
  assign RDATA = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit with a word memory model
module tb_load_store_unit;

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, R = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, sgn = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, wdata = '0;
  logic        ready, done, err, w_dm;
  logic [31:0] rdata, ad, wp;
  logic [31:0] pr = '0;
  logic [31:0] mem [0:15];

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          wdm_at;
    logic [31:0] wp;
  } exp_t;
  exp_t sbq[$];

  load_store_unit #(.MEM_WORDS(16)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .WE(we), .SIZE(size), .SIGNED(sgn),
    .ADDR(addr), .WDATA(wdata), .READY(ready), .DONE(done), .ERR(err),
    .RDATA(rdata), .W_DM(w_dm), .AD(ad), .WP(wp), .PR(pr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (w_dm) mem[ad[3:0]] <= wp;
    pr <= mem[ad[3:0]];
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request, keep REQ high while busy when hold is set, and score the completion.
  task automatic op(input string tag, input logic a_we, input logic [1:0] a_size, input logic a_sgn,
                    input logic [31:0] a_addr, input logic [31:0] a_wdata, input logic e_err,
                    input logic [31:0] e_rdata, input int e_lat, input int e_wdm_at,
                    input logic [31:0] e_wp, input logic hold);
    exp_t e;
    logic got;
    int lat, wdm_cnt, wdm_at;
    logic [31:0] wdm_ad, wdm_wp;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    e.err = e_err; e.rdata = e_rdata; e.lat = e_lat; e.wdm_at = e_wdm_at; e.wp = e_wp;
    sbq.push_back(e);
    req = 1'b1; we = a_we; size = a_size; sgn = a_sgn; addr = a_addr; wdata = a_wdata;
    @(posedge clk);
    got = 1'b0; lat = 0; wdm_cnt = 0; wdm_at = 0; wdm_ad = '0; wdm_wp = '0;
    for (int n = 1; n <= 8 && !got; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (hold) begin
          we = 1'b1; size = W; addr = 32'h0; wdata = 32'hBAD0BAD0;
        end else begin
          req = 1'b0;
        end
      end
      if (w_dm) begin
        wdm_cnt++; wdm_at = n; wdm_ad = ad; wdm_wp = wp;
      end
      if (done) begin
        got = 1'b1; lat = n; req = 1'b0;
      end
    end
    req = 1'b0;
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    e = sbq.pop_front();
    if (got) begin
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_err"}, 32'(err), 32'(e.err));
      chk({tag, "_rdata"}, rdata, e.rdata);
    end
    chk({tag, "_wdm_count"}, 32'(wdm_cnt), (e.wdm_at > 0) ? 32'd1 : 32'd0);
    if (e.wdm_at > 0) begin
      chk({tag, "_wdm_cycle"}, 32'(wdm_at), 32'(e.wdm_at));
      chk({tag, "_wdm_ad"}, wdm_ad, {2'b00, a_addr[31:2]});
      chk({tag, "_wdm_wp"}, wdm_wp, e.wp);
    end
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wdm", 32'(w_dm), 32'd0);
    chk("rst_ad", ad, 32'h0);
    chk("rst_wp", wp, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    op("st_w0",   1, W, 0, 32'h00, 32'h13579BDF, 0, 32'h0,        2, 1, 32'h13579BDF, 0);
    op("st_w8",   1, W, 0, 32'h08, 32'hDEADBEEF, 0, 32'h0,        2, 1, 32'hDEADBEEF, 0);
    op("ld_w8",   0, W, 0, 32'h08, 32'h0,        0, 32'hDEADBEEF, 3, 0, 32'h0,        1);
    op("ld_w0",   0, W, 0, 32'h00, 32'h0,        0, 32'h13579BDF, 3, 0, 32'h0,        0);
    op("st_w3c",  1, W, 0, 32'h3C, 32'hCAFEF00D, 0, 32'h13579BDF, 2, 1, 32'hCAFEF00D, 0);
    op("ld_w3c",  0, W, 0, 32'h3C, 32'h0,        0, 32'hCAFEF00D, 3, 0, 32'h0,        0);
    op("er_h3",   0, H, 1, 32'h03, 32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h0,        0);
    op("er_st40", 1, W, 0, 32'h40, 32'h12345678, 1, 32'hCAFEF00D, 1, 0, 32'h0,        0);
    op("er_sz3",  0, R, 0, 32'h00, 32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h0,        0);
    op("er_w2",   0, W, 0, 32'h02, 32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h0,        0);

`ifdef LSU_SUBWORD_EN
    op("st_base", 1, W, 0, 32'h08, 32'h11223344, 0, 32'hCAFEF00D, 2, 1, 32'h11223344, 0);
    op("st_b9",   1, B, 0, 32'h09, 32'h000000AA, 0, 32'hCAFEF00D, 4, 3, 32'h1122AA44, 0);
    op("ld_rmw",  0, W, 0, 32'h08, 32'h0,        0, 32'h1122AA44, 3, 0, 32'h0,        0);
    op("st_w4",   1, W, 0, 32'h04, 32'h000080FF, 0, 32'h1122AA44, 2, 1, 32'h000080FF, 0);
    op("ld_b5s",  0, B, 1, 32'h05, 32'h0,        0, 32'hFFFFFF80, 3, 0, 32'h0,        0);
    op("ld_b5u",  0, B, 0, 32'h05, 32'h0,        0, 32'h00000080, 3, 0, 32'h0,        0);
    op("ld_h4s",  0, H, 1, 32'h04, 32'h0,        0, 32'hFFFF80FF, 3, 0, 32'h0,        0);
    op("st_ha",   1, H, 0, 32'h0A, 32'h0000BEEF, 0, 32'hFFFF80FF, 4, 3, 32'hBEEFAA44, 0);
    // Abandon a byte store while it waits on the read half of its read-modify-write.
    req = 1'b1; we = 1'b1; size = B; sgn = 1'b0; addr = 32'h08; wdata = 32'h00000055;
`else
    op("er_b0",   0, B, 0, 32'h00, 32'h0,        1, 32'hCAFEF00D, 1, 0, 32'h0,        0);
    op("er_h0",   1, H, 0, 32'h00, 32'h0000FFFF, 1, 32'hCAFEF00D, 1, 0, 32'h0,        0);
    op("ld_w0b",  0, W, 0, 32'h00, 32'h0,        0, 32'h13579BDF, 3, 0, 32'h0,        0);
    // Abandon a word load while it waits on memory read data.
    req = 1'b1; we = 1'b0; size = W; sgn = 1'b0; addr = 32'h08; wdata = 32'h0;
`endif
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_wdm", 32'(w_dm), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rdata", rdata, 32'h0);
    repeat (2) @(negedge clk);
    chk("mid_rst_quiet", 32'(done | w_dm), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef LSU_SUBWORD_EN
    op("ld_after", 0, W, 0, 32'h08, 32'h0, 0, 32'hBEEFAA44, 3, 0, 32'h0, 0);
`else
    op("ld_after", 0, W, 0, 32'h08, 32'h0, 0, 32'hDEADBEEF, 3, 0, 32'h0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
